// File: rtl/addsub_arb_if.sv
// Request/result bus for addsub_arb: two requesters over valid/ready and
// one result channel back to the consumer.
interface addsub_arb_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic       req0_op;
    logic       req1_op;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       res_valid;
    logic       res_ready;
    logic       res_id;
    logic [3:0] res_sum;
    logic       res_carry;
    logic       res_ovf;
    logic       res_zero;

    // Clients and result consumer.
    modport master (
        output req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
        output res_ready,
        input  req_ready,
        input  res_valid, res_id, res_sum, res_carry, res_ovf, res_zero
    );

    // The arbiter/sequencer.
    modport slave (
        input  req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
        input  res_ready,
        output req_ready,
        output res_valid, res_id, res_sum, res_carry, res_ovf, res_zero
    );
endinterface

// File: rtl/addsub_arb.sv
// addsub_arb: two-requester arbiter and sequencer for a shared 4-bit
// add/subtract datapath. Subtraction is formed as A + ~B + 1 using the
// compl1 conditional ones'-complement unit and a single 5-bit adder.
// Optional build macro: ADDSUB_ARB_RR_EN selects round-robin arbitration;
// without it requester 0 has fixed priority.

// Conditional ones'-complement: out = cpl ? ~inp : inp.
module compl1 (
    output logic [3:0] out,
    input  logic [3:0] inp,
    input  logic       cpl
);
    assign out = cpl ? ~inp : inp;
endmodule

module addsub_arb (
    input  logic        clk,
    input  logic        reset_n,
    addsub_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       winner;
    logic       accept;

    logic       op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [3:0] bm_q;
    logic [3:0] cpl_out;
    logic [4:0] sum5;

    logic       id_q;
    logic [3:0] sum_q;
    logic       carry_q;
    logic       ovf_q;
    logic       zero_q;

`ifdef ADDSUB_ARB_RR_EN
    logic       last_grant;

    // Round-robin pick: on contention the requester not granted last wins.
    always_comb begin
        if (bus.req_valid == 2'b11) begin
            winner = ~last_grant;
        end else begin
            winner = ~bus.req_valid[0];
        end
    end

    // Last-grant register, moves only when a request is actually accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= winner;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid.
    assign winner = ~bus.req_valid[0];
`endif

    assign accept = (state == IDLE) && (|bus.req_valid);

    // Ready pulse to the winner only while IDLE.
    always_comb begin
        bus.req_ready = 2'b00;
        if (accept) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed walk IDLE->CPL->ADD->DONE, DONE waits on res_ready.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = CPL;
            CPL:  state_nxt = ADD;
            ADD:  state_nxt = DONE;
            DONE: if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    compl1 u_compl1 (
        .out (cpl_out),
        .inp (b_q),
        .cpl (op_q)
    );

    // A + BM + op as a 5-bit unsigned sum; op supplies the +1 of two's complement.
    assign sum5 = {1'b0, a_q} + {1'b0, bm_q} + {4'b0000, op_q};

    // Operand capture on accept, complement in CPL, result capture in ADD.
    always_ff @(posedge clk) begin
        // NOTE: every datapath register is reset too, so an aborted
        // transaction leaves no stale operands or results visible.
        if (!reset_n) begin
            op_q    <= 1'b0;
            a_q     <= 4'b0000;
            b_q     <= 4'b0000;
            bm_q    <= 4'b0000;
            id_q    <= 1'b0;
            sum_q   <= 4'b0000;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q <= winner;
                        op_q <= winner ? bus.req1_op : bus.req0_op;
                        a_q  <= winner ? bus.req1_a  : bus.req0_a;
                        b_q  <= winner ? bus.req1_b  : bus.req0_b;
                    end
                end
                CPL: begin
                    bm_q <= cpl_out;
                end
                ADD: begin
                    sum_q   <= sum5[3:0];
                    carry_q <= sum5[4];
                    ovf_q   <= (a_q[3] == bm_q[3]) && (sum5[3] != a_q[3]);
                    zero_q  <= (sum5[3:0] == 4'b0000);
                end
                default: ;
            endcase
        end
    end

    assign bus.res_valid = (state == DONE);
    assign bus.res_id    = id_q;
    assign bus.res_sum   = sum_q;
    assign bus.res_carry = carry_q;
    assign bus.res_ovf   = ovf_q;
    assign bus.res_zero  = zero_q;
endmodule
